// File: rtl/btn_debounce_pkg.sv
// Shared helpers for the pushbutton debouncer.
//   cnt_width    : bit width of a counter that must hold 0..max_val-1 (never 0)
//   params_legal : elaboration-time legality check of the block parameters
package btn_debounce_pkg;

  // Width of a counter holding values 0..max_val-1, floored at one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

  // N>=2, RATE>=1, SYNC_STAGES>=2.
  function automatic bit params_legal(input int unsigned n,
                                      input int unsigned rate,
                                      input int unsigned sync_stages);
    return (n >= 2) && (rate >= 1) && (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/btn_debounce_edge_if.sv
// Raw button inputs and debounced level/edge/hold outputs.
//   i_in    : raw asynchronous inputs (driven by master)
//   o_level : debounced level
//   o_rise  : one-cycle pulse on level 0->1
//   o_fall  : one-cycle pulse on level 1->0
//   o_hold  : one-cycle pulse after a long press
//   o_tick  : one-cycle sample strobe
interface btn_debounce_edge_if #(
  parameter int unsigned CH = 13
);
  logic [CH-1:0] i_in;
  logic [CH-1:0] o_level;
  logic [CH-1:0] o_rise;
  logic [CH-1:0] o_fall;
  logic [CH-1:0] o_hold;
  logic          o_tick;

  modport master (output i_in, input o_level, o_rise, o_fall, o_hold, o_tick);
  modport slave  (input i_in, output o_level, o_rise, o_fall, o_hold, o_tick);
endinterface

// File: rtl/btn_debounce_edge_chan.sv
// One debounce channel: synchroniser, sample shift register, level decision
// and saturating hold counter. All outputs registered.
//   clk, rst_n : clock, async active-low reset
//   tick       : shared sample strobe, valid for the current edge
//   in_raw     : raw asynchronous input
//   level/rise/fall/hold : debounced level and its one-cycle event pulses
module debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned N           = 4,
  parameter int unsigned HOLD_TICKS  = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic in_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);
  localparam int unsigned HC_W = cnt_width(HOLD_TICKS + 1);
  localparam logic [HC_W-1:0] HOLD_C = HC_W'(HOLD_TICKS);

  logic [SYNC_STAGES-1:0] sync;
  logic [N-1:0]           sh;
  logic [N-1:0]           nsh;
  logic [HC_W-1:0]        hc;
  logic [HC_W-1:0]        hc_inc;

  // Next shift value: the decision looks at the sample being shifted in.
  always_comb begin
    nsh    = {sh[N-2:0], sync[SYNC_STAGES-1]};
    hc_inc = hc + HC_W'(1);
  end

  // Synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], in_raw};
  end

  // Shift register, level, edge pulses and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      hold  <= 1'b0;
      hc    <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      hold <= 1'b0;
      if (tick) begin
        sh <= nsh;
        if (!level && (&nsh)) begin
          level <= 1'b1;
          rise  <= 1'b1;
          hc    <= '0;
        end else if (level && !(|nsh)) begin
          level <= 1'b0;
          fall  <= 1'b1;
          hc    <= '0;
        end else if (level) begin
          // Saturate at HOLD_TICKS so there is one hold pulse per press.
          if (hc < HOLD_C) begin
            hc   <= hc_inc;
            hold <= (hc_inc == HOLD_C);
          end
        end else begin
          hc <= '0;
        end
      end
    end
  end
endmodule

// File: rtl/btn_debounce_edge.sv
// Multi-channel pushbutton debouncer with rise/fall/long-press pulses.
// One shared prescaler produces the sample tick for all channels.
//   i_Sys_clk : clock
//   i_Rst_n   : async active-low reset
//   bus       : slave side of btn_debounce_edge_if (i_in in, o_* out)
module btn_debounce_edge
  import btn_debounce_pkg::*;
#(
  parameter int unsigned CH          = 13,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RATE        = 125000,
  parameter int unsigned N           = 4,
  parameter int unsigned HOLD_TICKS  = 500
) (
  input  logic                i_Sys_clk,
  input  logic                i_Rst_n,
  btn_debounce_edge_if.slave  bus
);
  localparam int unsigned CNT_W = cnt_width(RATE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);

  if (!params_legal(N, RATE, SYNC_STAGES)) begin : g_bad_params
    $error("btn_debounce_edge: illegal parameters (need N>=2, RATE>=1, SYNC_STAGES>=2)");
  end

  logic [CNT_W-1:0] cnt;
  logic             tick_c;
  logic             tick_q;
  logic [CH-1:0]    level;
  logic [CH-1:0]    rise;
  logic [CH-1:0]    fall;
  logic [CH-1:0]    hold;

  assign tick_c = (cnt == CNT_LAST);

  // Shared prescaler; o_tick is a registered copy of the strobe.
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt    <= tick_c ? '0 : cnt + CNT_W'(1);
      tick_q <= tick_c;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .N           (N),
      .HOLD_TICKS  (HOLD_TICKS)
    ) u_chan (
      .clk    (i_Sys_clk),
      .rst_n  (i_Rst_n),
      .tick   (tick_c),
      .in_raw (bus.i_in[c]),
      .level  (level[c]),
      .rise   (rise[c]),
      .fall   (fall[c]),
      .hold   (hold[c])
    );
  end

  assign bus.o_level = level;
  assign bus.o_rise  = rise;
  assign bus.o_fall  = fall;
  assign bus.o_hold  = hold;
  assign bus.o_tick  = tick_q;
endmodule

// File: tb/tb_btn_debounce_edge.sv
// Directed bench: CH=2, SYNC_STAGES=2, RATE=4, N=4, HOLD_TICKS=3, plus a
// RATE=1 instance. Edge numbers count clock edges after reset release.
module tb_btn_debounce_edge;
  logic clk = 1'b0;
  logic rst_n;
  int   e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  btn_debounce_edge_if #(.CH(2)) if_a ();
  btn_debounce_edge_if #(.CH(2)) if_b ();

  btn_debounce_edge #(
    .CH(2), .SYNC_STAGES(2), .RATE(4), .N(4), .HOLD_TICKS(3)
  ) u_dut_a (
    .i_Sys_clk (clk),
    .i_Rst_n   (rst_n),
    .bus       (if_a.slave)
  );

  btn_debounce_edge #(
    .CH(2), .SYNC_STAGES(2), .RATE(1), .N(4), .HOLD_TICKS(3)
  ) u_dut_b (
    .i_Sys_clk (clk),
    .i_Rst_n   (rst_n),
    .bus       (if_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after edge n.
  task automatic go(input int n);
    while (e < n) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    if_a.i_in = 2'b11;
    if_b.i_in = 2'b01;
    e         = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(if_a.o_level), 32'h0);
    check("rst_rise",  32'(if_a.o_rise),  32'h0);
    check("rst_fall",  32'(if_a.o_fall),  32'h0);
    check("rst_hold",  32'(if_a.o_hold),  32'h0);
    check("rst_tick",  32'(if_a.o_tick),  32'h0);
    check("rst_b_level", 32'(if_b.o_level), 32'h0);

    // Clean press on channel 0; release at the next falling edge.
    if_a.i_in = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;

    go(3);  check("tick_e3", 32'(if_a.o_tick), 32'h0);
    go(4);  check("tick_e4", 32'(if_a.o_tick), 32'h1);
    go(5);  check("tick_e5", 32'(if_a.o_tick), 32'h0);
            check("fast_rise_e5", 32'(if_b.o_rise), 32'h0);
    go(6);  check("fast_rise_e6", 32'(if_b.o_rise), 32'h1);
            check("fast_level_e6", 32'(if_b.o_level), 32'h1);
    go(8);  check("fast_hold_e8", 32'(if_b.o_hold), 32'h0);
    go(9);  check("fast_hold_e9", 32'(if_b.o_hold), 32'h1);
    go(15); check("press_level_e15", 32'(if_a.o_level), 32'h0);
    go(16); check("press_level_e16", 32'(if_a.o_level), 32'h1);
            check("press_rise_e16",  32'(if_a.o_rise),  32'h1);
    go(17); check("press_rise_e17",  32'(if_a.o_rise),  32'h0);
            check("press_level_e17", 32'(if_a.o_level), 32'h1);
    go(27); check("hold_e27", 32'(if_a.o_hold), 32'h0);
    go(28); check("hold_e28", 32'(if_a.o_hold), 32'h1);
    go(29); check("hold_e29", 32'(if_a.o_hold), 32'h0);
    go(32); check("hold_sat_e32", 32'(if_a.o_hold), 32'h0);
    go(36); check("hold_sat_e36", 32'(if_a.o_hold), 32'h0);

    // Release channel 0.
    go(40); if_a.i_in = 2'b00;
    go(55); check("rel_fall_e55",  32'(if_a.o_fall),  32'h0);
            check("rel_level_e55", 32'(if_a.o_level), 32'h1);
    go(56); check("rel_fall_e56",  32'(if_a.o_fall),  32'h1);
            check("rel_level_e56", 32'(if_a.o_level), 32'h0);
            check("rel_hold_e56",  32'(if_a.o_hold),  32'h0);
    go(57); check("rel_fall_e57",  32'(if_a.o_fall),  32'h0);

    // Glitch: high for exactly 8 cycles.
    go(60); if_a.i_in = 2'b01;
    go(68); if_a.i_in = 2'b00;
    for (int t = 72; t <= 84; t += 4) begin
      go(t);
      check("glitch_level", 32'(if_a.o_level), 32'h0);
      check("glitch_rise",  32'(if_a.o_rise),  32'h0);
      check("glitch_fall",  32'(if_a.o_fall),  32'h0);
    end

    // Short press: release after one post-rise tick.
    if_a.i_in = 2'b01;
    go(100); check("short_rise_e100", 32'(if_a.o_rise), 32'h1);
    go(104); if_a.i_in = 2'b00;
    go(119); check("short_level_e119", 32'(if_a.o_level), 32'h1);
    go(120); check("short_fall_e120",  32'(if_a.o_fall),  32'h1);
             check("short_level_e120", 32'(if_a.o_level), 32'h0);

    // Both channels together; ch0 hold counter must restart from 0.
    if_a.i_in = 2'b11;
    go(135); check("both_rise_e135", 32'(if_a.o_rise), 32'h0);
    go(136); check("both_rise_e136", 32'(if_a.o_rise), 32'h3);
    go(144); check("both_hold_e144", 32'(if_a.o_hold), 32'h0);
    go(147); check("both_hold_e147", 32'(if_a.o_hold), 32'h0);
    go(148); check("both_hold_e148", 32'(if_a.o_hold), 32'h3);
    go(150); check("both_level_e150", 32'(if_a.o_level), 32'h3);

    // Asynchronous reset mid-press, away from any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_level",   32'(if_a.o_level), 32'h0);
    check("mid_rst_fall",    32'(if_a.o_fall),  32'h0);
    check("mid_rst_b_level", 32'(if_b.o_level), 32'h0);
    @(posedge clk);
    #1;
    check("mid_rst_fall_next", 32'(if_a.o_fall), 32'h0);
    check("mid_rst_tick",      32'(if_a.o_tick), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
